// File: rtl/tlul_sram_responder.sv
// TL-UL device endpoint in front of a single-port SRAM with a one-cycle read latency.
// Requests are checked, performed on the SRAM, and acknowledged in acceptance order.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        Get            = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_sram_responder
    import tlul_pkg::*;
#(
    parameter int Depth       = 1024,
    parameter int AddrWidth   = $clog2(Depth),
    parameter int Outstanding = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  tl_h2d_t              tl_i,
    output tl_d2h_t              tl_o,
    output logic                 req_o,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [31:0]          wdata_o,
    output logic [31:0]          wmask_o,
    input  logic [31:0]          rdata_i
);

    localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int Slots = 1 << PtrW;
    localparam logic [3:0] MaxCount = 4'(Outstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Outstanding - 1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [PtrW:0] OccOne = (PtrW + 1)'(1);
    localparam logic [AddrWidth:0] DepthLim = (AddrWidth + 1)'(Depth);

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] size;
        logic [7:0] source;
        logic       error;
        logic       get;
    } meta_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        error;
        logic [31:0] data;
    } rsp_t;

    logic [3:0]          count_q, count_d;
    logic                stg_valid_q, stg_valid_d;
    meta_t               stg_q, stg_d;
    rsp_t                fifo_q [Slots];
    rsp_t                fifo_d [Slots];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]       occ_q, occ_d;

    logic                a_ready, accept, push, pop, d_valid;
    logic                is_get, op_ok, misaligned, out_of_range, req_err;
    logic [3:0]          covered;
    logic [AddrWidth-1:0] word_idx;
    rsp_t                push_entry;
    logic                unused_bits;

    assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:AddrWidth+2]};

    // Request decode: lanes a legal access of this size/offset may touch.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        covered = 4'b0000;
        case (tl_i.a_size)
            2'd0:    covered = 4'b0001 << tl_i.a_address[1:0];
            2'd1:    covered = 4'b0011 << tl_i.a_address[1:0];
            2'd2:    covered = 4'b1111;
            default: covered = 4'b0000;
        endcase
    end

    assign word_idx     = tl_i.a_address[AddrWidth+1:2];
    assign is_get       = (tl_i.a_opcode == Get);
    assign op_ok        = is_get || (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign misaligned   = ((tl_i.a_size == 2'd1) && tl_i.a_address[0]) ||
                          ((tl_i.a_size == 2'd2) && (tl_i.a_address[1:0] != 2'b00));
    assign out_of_range = ({1'b0, word_idx} >= DepthLim);
    assign req_err      = !op_ok || (tl_i.a_size > 2'd2) || misaligned || out_of_range ||
                          ((tl_i.a_mask & ~covered) != 4'b0000) ||
                          ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != covered));

    // a_ready comes from registered state only, so it never waits on a_valid.
    assign a_ready = !rst_i && (count_q < MaxCount);
    assign accept  = tl_i.a_valid && a_ready;
    assign req_o   = accept && !req_err;
    assign we_o    = req_o && !is_get;
    assign addr_o  = word_idx;
    assign wdata_o = tl_i.a_data;
    assign wmask_o = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                      {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};

    assign d_valid = (occ_q != '0);
    assign push    = stg_valid_q;
    assign pop     = d_valid && tl_i.d_ready;

    always_comb begin
        stg_valid_d   = accept;
        stg_d.opcode  = is_get ? AccessAckData : AccessAck;
        stg_d.size    = tl_i.a_size;
        stg_d.source  = tl_i.a_source;
        stg_d.error   = req_err;
        stg_d.get     = is_get;

        push_entry.opcode = stg_q.opcode;
        push_entry.size   = stg_q.size;
        push_entry.source = stg_q.source;
        push_entry.error  = stg_q.error;
        push_entry.data   = stg_q.get ? (stg_q.error ? 32'hFFFF_FFFF : rdata_i) : 32'h0;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrOne;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OccOne;
            2'b01:   occ_d = occ_q - OccOne;
            default: occ_d = occ_q;
        endcase

        case ({accept, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            count_q     <= '0;
            stg_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            count_q     <= count_d;
            stg_valid_q <= stg_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // NOTE: response storage has no reset; the valid bit and pointers alone decide what is live.
    always_ff @(posedge clk_i) begin
        stg_q  <= stg_d;
        fifo_q <= fifo_d;
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid;
        tl_o.d_opcode = fifo_q[rd_ptr_q].opcode;
        tl_o.d_size   = fifo_q[rd_ptr_q].size;
        tl_o.d_source = fifo_q[rd_ptr_q].source;
        tl_o.d_data   = fifo_q[rd_ptr_q].data;
        tl_o.d_error  = fifo_q[rd_ptr_q].error;
        tl_o.a_ready  = a_ready;
    end

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Directed bench for tlul_sram_responder: Depth=1000, Outstanding=3, with a behavioural SRAM.
module tb_tlul_sram_responder;
    import tlul_pkg::*;

    localparam int Depth = 1000;
    localparam int Outst = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        req_o, we_o;
    logic [9:0]  addr_o;
    logic [31:0] wdata_o, wmask_o, rdata_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
    } beat_t;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        exp_req;
        logic [2:0]  exp_op;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    beat_t       beats[$];
    beat_t       mon_b;
    logic [31:0] mem [1024];

    tlul_sram_responder #(.Depth(Depth), .Outstanding(Outst)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .req_o   (req_o),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .wmask_o (wmask_o),
        .rdata_i (rdata_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural single-port SRAM, read data one cycle after the strobe.
    always @(posedge clk_i) begin
        if (req_o) begin
            if (we_o) mem[addr_o] <= (mem[addr_o] & ~wmask_o) | (wdata_o & wmask_o);
            else      rdata_i <= mem[addr_o];
        end
    end

    // D-channel beat recorder; sampled mid-cycle, the handshake completes at the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && tl_o.d_valid && tl_i.d_ready) begin
            mon_b.cyc  = cyc;
            mon_b.op   = tl_o.d_opcode;
            mon_b.size = tl_o.d_size;
            mon_b.src  = tl_o.d_source;
            mon_b.data = tl_o.d_data;
            mon_b.err  = tl_o.d_error;
            beats.push_back(mon_b);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                           input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_param   = 3'd0;
        tl_i.a_size    = size;
        tl_i.a_source  = src;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                         output logic o_req, output logic o_we, output logic [9:0] o_addr,
                         output logic [31:0] o_wmask, output int o_cyc);
        logic got;
        got = 1'b0;
        o_req = 1'b0; o_we = 1'b0; o_addr = '0; o_wmask = '0; o_cyc = 0;
        set_req(op, size, src, addr, mask, data);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk_i);
            if (tl_o.a_ready) begin
                got = 1'b1;
                o_req = req_o; o_we = we_o; o_addr = addr_o; o_wmask = wmask_o; o_cyc = cyc;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL issue_timeout: a_ready stayed 0 for source %h", src);
        end
        step();
        tl_i.a_valid = 1'b0;
    endtask

    task automatic wait_beat(output beat_t b);
        b.cyc = -1; b.op = '0; b.size = '0; b.src = '0; b.data = '0; b.err = 1'b0;
        for (int n = 0; n < 20 && beats.size() == 0; n++) step();
        if (beats.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_timeout: no D beat within 20 cycles");
        end else begin
            b = beats.pop_front();
        end
    endtask

    task automatic test_reset();
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        set_req(Get, 2'd2, 8'h01, 32'h0, 4'hF, 32'h0);
        repeat (2) step();
        @(negedge clk_i);
        checks++; if (tl_o.d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid: got %b want 0", tl_o.d_valid); end
        checks++; if (tl_o.a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %b want 0", tl_o.a_ready); end
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req_o); end
        checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", we_o); end
        step();
        tl_i.a_valid = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (tl_o.a_ready !== 1'b1) begin errors++; $display("FAIL post_rst_a_ready: got %b want 1", tl_o.a_ready); end
        checks++; if (tl_o.d_valid !== 1'b0) begin errors++; $display("FAIL post_rst_d_valid: got %b want 0", tl_o.d_valid); end
        step();
    endtask

    task automatic test_put_get();
        logic r, w; logic [9:0] a; logic [31:0] m; int c; beat_t b;
        issue(PutFullData, 2'd2, 8'h11, 32'h10, 4'hF, 32'hDEAD_BEEF, r, w, a, m, c);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL put_req: got %b want 1", r); end
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL put_we: got %b want 1", w); end
        checks++; if (a !== 10'd4) begin errors++; $display("FAIL put_addr: got %0d want 4", a); end
        checks++; if (m !== 32'hFFFF_FFFF) begin errors++; $display("FAIL put_wmask: got %h want ffffffff", m); end
        wait_beat(b);
        checks++; if (b.op !== 3'd0) begin errors++; $display("FAIL put_d_opcode: got %0d want 0", b.op); end
        checks++; if (b.err !== 1'b0) begin errors++; $display("FAIL put_d_error: got %b want 0", b.err); end
        checks++; if (b.src !== 8'h11) begin errors++; $display("FAIL put_d_source: got %h want 11", b.src); end
        checks++; if (b.cyc - c !== 2) begin errors++; $display("FAIL put_latency: got %0d want 2", b.cyc - c); end
        checks++; if (b.data !== 32'h0) begin errors++; $display("FAIL put_d_data: got %h want 0", b.data); end

        issue(Get, 2'd2, 8'h22, 32'h10, 4'hF, 32'h0, r, w, a, m, c);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL get_req: got %b want 1", r); end
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL get_we: got %b want 0", w); end
        checks++; if (a !== 10'd4) begin errors++; $display("FAIL get_addr: got %0d want 4", a); end
        wait_beat(b);
        checks++; if (b.op !== 3'd1) begin errors++; $display("FAIL get_d_opcode: got %0d want 1", b.op); end
        checks++; if (b.data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL get_d_data: got %h want deadbeef", b.data); end
        checks++; if (b.src !== 8'h22) begin errors++; $display("FAIL get_d_source: got %h want 22", b.src); end
        checks++; if (b.size !== 2'd2) begin errors++; $display("FAIL get_d_size: got %0d want 2", b.size); end
        checks++; if (b.err !== 1'b0) begin errors++; $display("FAIL get_d_error: got %b want 0", b.err); end
    endtask

    task automatic test_partial();
        logic r, w; logic [9:0] a; logic [31:0] m; int c; beat_t b;
        issue(PutPartialData, 2'd0, 8'h33, 32'h11, 4'h2, 32'h0000_AB00, r, w, a, m, c);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL part_req: got %b want 1", r); end
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL part_we: got %b want 1", w); end
        checks++; if (m !== 32'h0000_FF00) begin errors++; $display("FAIL part_wmask: got %h want 0000ff00", m); end
        wait_beat(b);
        checks++; if (b.err !== 1'b0) begin errors++; $display("FAIL part_d_error: got %b want 0", b.err); end
        checks++; if (b.op !== 3'd0) begin errors++; $display("FAIL part_d_opcode: got %0d want 0", b.op); end
        issue(Get, 2'd2, 8'h34, 32'h10, 4'hF, 32'h0, r, w, a, m, c);
        wait_beat(b);
        checks++; if (b.data !== 32'hDEAD_ABEF) begin errors++; $display("FAIL part_readback: got %h want deadabef", b.data); end
    endtask

    task automatic test_errors();
        vec_t vecs [8];
        logic r, w; logic [9:0] a; logic [31:0] m; int c; beat_t b;
        vecs = '{
            '{3'd4, 2'd3, 32'h0000_0000, 4'hF, 1'b0, 3'd1, 32'hFFFF_FFFF, 1'b1},
            '{3'd0, 2'd2, 32'h0000_0012, 4'hF, 1'b0, 3'd0, 32'h0000_0000, 1'b1},
            '{3'd5, 2'd2, 32'h0000_0000, 4'hF, 1'b0, 3'd0, 32'h0000_0000, 1'b1},
            '{3'd4, 2'd2, 32'h0000_0FA0, 4'hF, 1'b0, 3'd1, 32'hFFFF_FFFF, 1'b1},
            '{3'd1, 2'd0, 32'h0000_0000, 4'h2, 1'b0, 3'd0, 32'h0000_0000, 1'b1},
            '{3'd0, 2'd2, 32'h0000_0008, 4'h7, 1'b0, 3'd0, 32'h0000_0000, 1'b1},
            '{3'd4, 2'd2, 32'h0000_0F9C, 4'hF, 1'b1, 3'd1, 32'hA000_03E7, 1'b0},
            '{3'd4, 2'd1, 32'h0000_0022, 4'hC, 1'b1, 3'd1, 32'hA000_0008, 1'b0}
        };
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].size, 8'(8'h80 + i), vecs[i].addr, vecs[i].mask, 32'h0, r, w, a, m, c);
            wait_beat(b);
            checks++; if (r !== vecs[i].exp_req) begin errors++; $display("FAIL err%0d_req: got %b want %b", i, r, vecs[i].exp_req); end
            checks++; if (b.err !== vecs[i].exp_err) begin errors++; $display("FAIL err%0d_d_error: got %b want %b", i, b.err, vecs[i].exp_err); end
            checks++; if (b.op !== vecs[i].exp_op) begin errors++; $display("FAIL err%0d_d_opcode: got %0d want %0d", i, b.op, vecs[i].exp_op); end
            checks++; if (b.data !== vecs[i].exp_data) begin errors++; $display("FAIL err%0d_d_data: got %h want %h", i, b.data, vecs[i].exp_data); end
            checks++; if (b.src !== 8'(8'h80 + i)) begin errors++; $display("FAIL err%0d_d_source: got %h want %h", i, b.src, 8'(8'h80 + i)); end
        end
    endtask

    task automatic test_back_to_back();
        int acc [8];
        beats.delete();
        tl_i.d_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_req(Get, 2'd2, 8'(8'h50 + k), 32'(32'h100 + 4 * k), 4'hF, 32'h0);
            @(negedge clk_i);
            acc[k] = cyc;
            checks++; if (tl_o.a_ready !== 1'b1) begin errors++; $display("FAIL b2b_a_ready%0d: got %b want 1", k, tl_o.a_ready); end
            step();
        end
        tl_i.a_valid = 1'b0;
        for (int n = 0; n < 30 && beats.size() < 8; n++) step();
        checks++; if (beats.size() !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", beats.size()); end
        for (int k = 0; k < 8 && k < beats.size(); k++) begin
            checks++; if (beats[k].cyc !== acc[0] + 2 + k) begin errors++; $display("FAIL b2b_cycle%0d: got %0d want %0d", k, beats[k].cyc, acc[0] + 2 + k); end
            checks++; if (beats[k].src !== 8'(8'h50 + k)) begin errors++; $display("FAIL b2b_source%0d: got %h want %h", k, beats[k].src, 8'(8'h50 + k)); end
            checks++; if (beats[k].data !== 32'(32'hA000_0040 + k)) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", k, beats[k].data, 32'(32'hA000_0040 + k)); end
        end
        beats.delete();
    endtask

    task automatic test_backpressure();
        int acc, head_changes;
        logic [7:0] src, head_src;
        logic [31:0] head_data;
        logic have_head, took;
        beat_t b;
        beats.delete();
        tl_i.d_ready = 1'b0;
        acc = 0; head_changes = 0; have_head = 1'b0; src = 8'h60; head_src = '0; head_data = '0;
        set_req(Get, 2'd2, src, 32'h200, 4'hF, 32'h0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_i);
            took = tl_o.a_ready;
            if (took) acc++;
            if (tl_o.d_valid) begin
                if (!have_head) begin
                    have_head = 1'b1; head_src = tl_o.d_source; head_data = tl_o.d_data;
                end else if (tl_o.d_source !== head_src || tl_o.d_data !== head_data) begin
                    head_changes++;
                end
            end
            step();
            if (took) begin
                src = src + 8'd1;
                set_req(Get, 2'd2, src, 32'(32'h200 + 4 * acc), 4'hF, 32'h0);
            end
        end
        checks++; if (acc !== 3) begin errors++; $display("FAIL bp_accepts: got %0d want 3", acc); end
        checks++; if (head_changes !== 0) begin errors++; $display("FAIL bp_head_stable: got %0d changes want 0", head_changes); end
        checks++; if (head_src !== 8'h60) begin errors++; $display("FAIL bp_head_source: got %h want 60", head_src); end
        checks++; if (head_data !== 32'hA000_0080) begin errors++; $display("FAIL bp_head_data: got %h want a0000080", head_data); end
        @(negedge clk_i);
        checks++; if (tl_o.a_ready !== 1'b0) begin errors++; $display("FAIL bp_full_a_ready: got %b want 0", tl_o.a_ready); end
        step();
        tl_i.a_valid = 1'b0;
        tl_i.d_ready = 1'b1;
        @(negedge clk_i);
        checks++; if (tl_o.d_valid !== 1'b1) begin errors++; $display("FAIL bp_release_d_valid: got %b want 1", tl_o.d_valid); end
        checks++; if (tl_o.a_ready !== 1'b0) begin errors++; $display("FAIL bp_release_a_ready: got %b want 0", tl_o.a_ready); end
        step();
        @(negedge clk_i);
        checks++; if (tl_o.a_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop_a_ready: got %b want 1", tl_o.a_ready); end
        step();
        for (int k = 0; k < 3; k++) begin
            wait_beat(b);
            checks++; if (b.src !== 8'(8'h60 + k)) begin errors++; $display("FAIL bp_drain_source%0d: got %h want %h", k, b.src, 8'(8'h60 + k)); end
            checks++; if (b.data !== 32'(32'hA000_0080 + k)) begin errors++; $display("FAIL bp_drain_data%0d: got %h want %h", k, b.data, 32'(32'hA000_0080 + k)); end
        end
    endtask

    task automatic test_reset_midop();
        logic r, w; logic [9:0] a; logic [31:0] m; int c, acc; logic [7:0] src; logic took; beat_t b;
        beats.delete();
        tl_i.d_ready = 1'b0;
        issue(Get, 2'd2, 8'h70, 32'h0, 4'hF, 32'h0, r, w, a, m, c);
        issue(Get, 2'd2, 8'h71, 32'h4, 4'hF, 32'h0, r, w, a, m, c);
        repeat (2) step();
        @(negedge clk_i);
        checks++; if (tl_o.d_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", tl_o.d_valid); end
        step();
        rst_i = 1'b1;
        set_req(Get, 2'd2, 8'h7F, 32'h0, 4'hF, 32'h0);
        step();
        @(negedge clk_i);
        checks++; if (tl_o.d_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_d_valid: got %b want 0", tl_o.d_valid); end
        checks++; if (tl_o.a_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_a_ready: got %b want 0", tl_o.a_ready); end
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b want 0", req_o); end
        step();
        rst_i = 1'b0;
        tl_i.a_valid = 1'b0;
        tl_i.d_ready = 1'b1;
        repeat (8) step();
        checks++; if (beats.size() !== 0) begin errors++; $display("FAIL mid_stale_beats: got %0d want 0", beats.size()); end
        tl_i.d_ready = 1'b0;
        acc = 0; src = 8'h78;
        set_req(Get, 2'd2, src, 32'h0, 4'hF, 32'h0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk_i);
            took = tl_o.a_ready;
            if (took) acc++;
            step();
            if (took) begin
                src = src + 8'd1;
                set_req(Get, 2'd2, src, 32'h0, 4'hF, 32'h0);
            end
        end
        tl_i.a_valid = 1'b0;
        checks++; if (acc !== 3) begin errors++; $display("FAIL mid_post_accepts: got %0d want 3", acc); end
        tl_i.d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_beat(b);
            checks++; if (b.src !== 8'(8'h78 + k)) begin errors++; $display("FAIL mid_post_source%0d: got %h want %h", k, b.src, 8'(8'h78 + k)); end
        end
        repeat (4) step();
        checks++; if (beats.size() !== 0) begin errors++; $display("FAIL mid_extra_beats: got %0d want 0", beats.size()); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_put_get();
        test_partial();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
